// File: rtl/ysyx_22050854_pkg.sv
// Shared definitions for the NPC core.
//   IFU_RESET_PC : default PC after reset
//   NOP_INSTR    : RV64 NOP encoding (addi x0, x0, 0)
//   ifu_slot_t   : one fetch-queue slot (pc, instr, filled)
package ysyx_22050854_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        filled;
  } ifu_slot_t;

endpackage

// File: rtl/ysyx_22050854_ifu_queue.sv
// In-order slot queue of the instruction fetch unit.
// A slot is allocated when its request is accepted, filled when the response
// arrives (responses return in request order) and freed when decode takes it.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   alloc, alloc_pc      allocate slot at the alloc pointer for this pc
//   fill, fill_instr     write instruction into slot at the fill pointer
//   pop                  free the head slot
//   flush                free every slot and zero all pointers
//   count                occupied slots
//   pend                 allocated slots still waiting for their response
//   head                 contents of the head slot
module ysyx_22050854_ifu_queue
  import ysyx_22050854_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc,
  input  logic [63:0]   alloc_pc,
  input  logic          fill,
  input  logic [31:0]   fill_instr,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [CW-1:0] pend,
  output ifu_slot_t     head
);

  ifu_slot_t     slots [DEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;

  assign head = slots[head_ptr];

  // The three writes never target the same slot: alloc hits a free slot, fill
  // an allocated unfilled one, pop a filled one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend      <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend      <= '0;
    end else begin
      if (alloc) begin
        slots[alloc_ptr] <= '{pc: alloc_pc, instr: 32'h0, filled: 1'b0};
        alloc_ptr        <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        slots[fill_ptr].instr  <= fill_instr;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PW'(1);
      end
      if (pop) begin
        slots[head_ptr].filled <= 1'b0;
        head_ptr               <= head_ptr + PW'(1);
      end
      count <= count + CW'(alloc) - CW'(pop);
      pend  <= pend + CW'(alloc) - CW'(fill);
    end
  end

endmodule

// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: holds the PC, issues word fetches, buffers returned
// instructions in ysyx_22050854_ifu_queue and hands them to decode in order.
// A redirect flushes the queue; responses still in flight for flushed or
// same-cycle requests are counted in drop and discarded on arrival.
// Optional feature macro: YSYX_22050854_IFU_MISALIGN_CHK_EN
//   defined   : a misaligned redirect halts fetch and presents a single NOP
//               entry flagged id_misalign until an aligned redirect
//   undefined : redirect_pc[1:0] is forced to zero, id_misalign is 0
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         fetch request (word aligned address)
//   imem_resp_valid/data              in-order response, no backpressure
//   redirect_valid/pc                 flush and restart fetch
//   id_valid/ready/instr/pc/misalign  instruction to decode
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high; valid never depends combinationally on ready of the same interface.
module ysyx_22050854_ifu
  import ysyx_22050854_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic        id_misalign
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [63:0]   pc;
  logic [63:0]   redirect_tgt;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW-1:0] pend;
  ifu_slot_t     head;
  logic          halted;
  logic          mis_sel;
  logic          req_fire;
  logic          id_fire;
  logic          drop_zero;

  assign drop_zero      = (drop == '0);
  // rst_n gating keeps the request quiet while reset is held.
  assign imem_req_valid = rst_n && (count < CW'(DEPTH)) && !halted;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign id_fire        = id_valid && id_ready;

`ifdef YSYX_22050854_IFU_MISALIGN_CHK_EN
  logic        mis_pend;
  logic [63:0] mis_pc;

  assign redirect_tgt = redirect_pc;
  // The marker entry waits until every stale response has been discarded.
  assign mis_sel      = mis_pend && drop_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted   <= 1'b0;
      mis_pend <= 1'b0;
      mis_pc   <= '0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        halted   <= 1'b1;
        mis_pend <= 1'b1;
        mis_pc   <= redirect_pc;
      end else begin
        halted   <= 1'b0;
        mis_pend <= 1'b0;
      end
    end else if (id_fire && mis_sel) begin
      mis_pend <= 1'b0;
    end
  end
`else
  assign redirect_tgt = redirect_pc & ~64'h3;
  assign halted       = 1'b0;
  assign mis_sel      = 1'b0;
`endif

  // Redirect: everything unfilled, plus this cycle's request, will still
  // return; this cycle's response is consumed here either way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      drop <= '0;
    end else if (redirect_valid) begin
      pc   <= redirect_tgt;
      drop <= drop + pend + CW'(req_fire) - CW'(imem_resp_valid);
    end else begin
      if (req_fire) pc <= pc + 64'd4;
      if (imem_resp_valid && !drop_zero) drop <= drop - CW'(1);
    end
  end

  ysyx_22050854_ifu_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc      (req_fire && !redirect_valid),
    .alloc_pc   (pc),
    .fill       (imem_resp_valid && drop_zero && !redirect_valid),
    .fill_instr (imem_resp_data),
    .pop        (id_fire && !mis_sel),
    .flush      (redirect_valid),
    .count      (count),
    .pend       (pend),
    .head       (head)
  );

  always_comb begin
    id_valid    = head.filled;
    id_instr    = head.filled ? head.instr : 32'h0;
    id_pc       = head.filled ? head.pc : 64'h0;
    id_misalign = 1'b0;
    if (mis_sel) begin
      id_valid    = 1'b1;
      id_instr    = NOP_INSTR;
      id_pc       = redirect_tgt_q();
      id_misalign = 1'b1;
    end
  end

`ifdef YSYX_22050854_IFU_MISALIGN_CHK_EN
  function automatic logic [63:0] redirect_tgt_q();
    return mis_pc;
  endfunction
`else
  function automatic logic [63:0] redirect_tgt_q();
    return 64'h0;
  endfunction
`endif

endmodule
